adder_station: RTL and testbench
================================

Name: adder_station

Overview:
- Reservation station plus integer adder for a single functional-unit slot. Sits directly downstream of the reorder buffer's issue port.
- Accepts an issued instruction tagged with its ROB index and resolves operands from the register file/status or by snooping the CDB data bus.
- Executes ADD/SUB/ADDI/SUBI and returns the result tagged with the ROB index for the CDB packer.
- One instance per adder FU; `busy` and `kill` connect to this FU's bit of the ROB `busy`/`reset_out` vectors.

Parameters:
- WORD_SIZE, 32, data/instruction width
- RB_SIZE, 8, ROB entries (CDB slices)
- RB_INDEX, 4, ROB tag width; tag value all-ones = READY
- REG_INDEX, 5, register index width
- FU_INDEX, 4, FU id width
- FU_ID, 0, this station's FU number
- ADD_LATENCY, 2, execute cycles (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- kill  in  1  flush from ROB (`reset_out` bit FU_ID), level-sampled
- issue_fu  in  FU_INDEX  target FU of the issue bus; NO_FU = all-ones
- issue_inst  in  WORD_SIZE  issued instruction
- issue_rb  in  RB_INDEX  ROB tag of the issued instruction
- numj  out  REG_INDEX  rs field of issue_inst (combinational)
- numk  out  REG_INDEX  rt field of issue_inst (combinational)
- vj, vk  in  WORD_SIZE  register values for numj/numk
- qj, qk  in  RB_INDEX  producing ROB tag; READY = value valid
- cdb_data  in  RB_SIZE*WORD_SIZE  CDB data, slice i = ROB entry i
- cdb_valid  in  RB_SIZE  CDB valid per ROB entry
- busy  out  1  station occupied
- res_valid  out  1  result strobe, one cycle
- res_rb  out  RB_INDEX  ROB tag of the result
- res_data  out  WORD_SIZE  sum/difference

Behaviour:
- Instruction fields:
  - op = [31:28], rd = [27:23], rs = [22:18], rt = [17:13].
  - imm = [17:0], sign-extended to WORD_SIZE for ADDI/SUBI.
- Reset (async):
  - busy = 0, res_valid = 0, res_rb = 0, res_data = 0.
  - state = IDLE, operand tags = READY, exec counter = 0.
- Accept:
  - Occurs at posedge in IDLE when issue_fu == FU_ID and kill == 0.
  - Latches op, imm and tag.
  - busy goes high in the same cycle edge, so the ROB never double-issues.
  - issue_fu == FU_ID while busy is an ROB error: ignore it and `$display` a fatal message.
- Operand capture at accept, per operand (j, k):
  - q == READY: take v.
  - Else if cdb_valid[q]: take the cdb_data slice q.
  - Else store tag q and snoop.
  - Immediate ops use imm as the k operand; qk is ignored.
- States:
  - IDLE -> WAIT on accept.
  - WAIT -> EXEC on the first edge at which both operands are resolved. Resolution can happen at accept, giving zero wait cycles.
  - WAIT snoop: each edge, a pending tag t with cdb_valid[t] = 1 captures its slice and becomes READY. Both operands may resolve in the same edge.
  - EXEC counts ADD_LATENCY cycles -> DONE.
  - DONE drives res_valid = 1, res_rb = tag, res_data = result for exactly one cycle -> IDLE. busy is low from the next edge.
- Latency: accept-with-ready-operands to res_valid = ADD_LATENCY+1 edges.
- Arithmetic: modulo 2^WORD_SIZE, no overflow flag. SUB/SUBI compute j - k.
- kill:
  - Any state -> IDLE at the next edge; busy = 0, res_valid = 0, pending tags dropped.
  - kill has priority over accept in the same cycle and over a DONE strobe.
- Unknown opcode accepted: treat as ADD and `$display` a warning.
- Tag comparison ignores cdb_valid bits with index >= RB_SIZE. READY never matches a CDB slice.

Decomposition:
- Shared package (existing parameters include):
  - WORD_SIZE, RB_SIZE, RB_INDEX, REG_INDEX, FU_INDEX.
  - READY, NO_FU, INST_ADD/SUB/ADDI/SUBI, field start constants, ADDER_START/ADDER_NUM.
- One natural sub-module: `operand_snoop`, holding value + tag for one operand and doing the CDB slice select/capture. Instantiate it twice (j, k).

Test Plan:
- ADD with qj = qk = READY, vj = 7, vk = 5, issue_rb = 3: busy at edge 1; res_valid with res_rb = 3, res_data = 12 at edge ADD_LATENCY+1; busy low after.
- SUBI, rs ready = 10, imm = 18'h3FFFF (-1): res_data = 11. SUB 3 - 5: res_data = 32'hFFFFFFFE.
- ADD with qj = 2 pending: cdb_valid[2] = 1, slice 2 = 100 after 4 cycles; vk = 1 ready -> res_data = 101, res_valid exactly ADD_LATENCY+1 edges after the capture.
- Both operands pending on tags 1 and 6, resolved in the same cycle -> single transition to EXEC, correct sum.
- kill asserted in WAIT, in EXEC, and in the DONE cycle -> no res_valid, busy = 0 next edge. kill together with an issue -> not accepted.
- Async reset mid-EXEC -> outputs zero immediately; next issue behaves normally.

Source files
------------

// File: rtl/adder_station_pkg.sv
// Shared widths, tags, opcodes and state encoding
// for the adder reservation station.
package adder_station_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 4;
    localparam int REG_INDEX = 5;
    localparam int FU_INDEX  = 4;

    localparam logic [RB_INDEX-1:0] READY = '1;
    localparam logic [FU_INDEX-1:0] NO_FU = '1;

    localparam logic [3:0] INST_ADD  = 4'h0;
    localparam logic [3:0] INST_SUB  = 4'h1;
    localparam logic [3:0] INST_ADDI = 4'h2;
    localparam logic [3:0] INST_SUBI = 4'h3;

    localparam int OP_START  = 28;
    localparam int RD_START  = 23;
    localparam int RS_START  = 18;
    localparam int RT_START  = 13;
    localparam int IMM_WIDTH = 18;

    localparam int ADDER_START = 0;
    localparam int ADDER_NUM   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_DONE
    } state_t;

    function automatic logic [WORD_SIZE-1:0] sext_imm(
        input logic [IMM_WIDTH-1:0] imm
    );
        return {{(WORD_SIZE-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

endpackage

// File: rtl/adder_station_snoop.sv
// One source operand: value plus producing ROB tag,
// resolved from the issue bus or by snooping the CDB.
module operand_snoop
    import adder_station_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kill,
    input  logic                         load,
    input  logic [RB_INDEX-1:0]          load_tag,
    input  logic [WORD_SIZE-1:0]         load_val,
    input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data,
    input  logic [RB_SIZE-1:0]           cdb_valid,
    output logic [WORD_SIZE-1:0]         value,
    output logic                         ready,
    output logic                         load_ready
);

    logic [RB_INDEX-1:0]  tag;
    logic [RB_INDEX-1:0]  look_tag;
    logic                 hit;
    logic [WORD_SIZE-1:0] hit_data;

    // The stored tag is READY whenever the station is idle,
    // so one slice lookup serves both load and snoop.
    assign look_tag = load ? load_tag : tag;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            if (look_tag != READY && look_tag == RB_INDEX'(i)) begin
                hit      = cdb_valid[i];
                hit_data = cdb_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign ready      = tag == READY;
    assign load_ready = (load_tag == READY) || hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag   <= READY;
            value <= '0;
        end else if (kill) begin
            tag <= READY;
        end else if (load) begin
            if (load_tag == READY) begin
                tag   <= READY;
                value <= load_val;
            end else if (hit) begin
                tag   <= READY;
                value <= hit_data;
            end else begin
                tag <= load_tag;
            end
        end else if (!ready && hit) begin
            tag   <= READY;
            value <= hit_data;
        end
    end

endmodule

// File: rtl/adder_station.sv
// Single-slot reservation station with an integer adder;
// result goes out tagged with its ROB index.
module adder_station
    import adder_station_pkg::*;
#(
    parameter int FU_ID       = 0,
    parameter int ADD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kill,
    input  logic [FU_INDEX-1:0]          issue_fu,
    input  logic [WORD_SIZE-1:0]         issue_inst,
    input  logic [RB_INDEX-1:0]          issue_rb,
    output logic [REG_INDEX-1:0]         numj,
    output logic [REG_INDEX-1:0]         numk,
    input  logic [WORD_SIZE-1:0]         vj,
    input  logic [WORD_SIZE-1:0]         vk,
    input  logic [RB_INDEX-1:0]          qj,
    input  logic [RB_INDEX-1:0]          qk,
    input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data,
    input  logic [RB_SIZE-1:0]           cdb_valid,
    output logic                         busy,
    output logic                         res_valid,
    output logic [RB_INDEX-1:0]          res_rb,
    output logic [WORD_SIZE-1:0]         res_data
);

    localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           op_q;
    logic [3:0]           op_in;
    logic [RB_INDEX-1:0]  tag_q;
    logic                 is_imm;
    logic                 accept;
    logic                 j_ready, k_ready;
    logic                 j_load_ready, k_load_ready;
    logic [WORD_SIZE-1:0] j_val, k_val;
    logic [WORD_SIZE-1:0] k_load_val;
    logic [RB_INDEX-1:0]  k_load_tag;
    logic [WORD_SIZE-1:0] result;

    assign op_in  = issue_inst[OP_START +: 4];
    assign numj   = issue_inst[RS_START +: REG_INDEX];
    assign numk   = issue_inst[RT_START +: REG_INDEX];
    assign is_imm = op_in == INST_ADDI || op_in == INST_SUBI;

    assign k_load_tag = is_imm ? READY : qk;
    assign k_load_val = is_imm ?
        sext_imm(issue_inst[IMM_WIDTH-1:0]) : vk;

    assign busy   = state != S_IDLE;
    assign accept = !busy && !kill
                 && issue_fu == FU_INDEX'(FU_ID);

    // Unknown opcodes fall through to ADD.
    assign result = (op_q == INST_SUB || op_q == INST_SUBI)
                  ? j_val - k_val : j_val + k_val;

    // A flush in the strobe cycle must still suppress it.
    assign res_valid = state == S_DONE && !kill;

    operand_snoop u_j (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .load      (accept),
        .load_tag  (qj),
        .load_val  (vj),
        .cdb_data  (cdb_data),
        .cdb_valid (cdb_valid),
        .value     (j_val),
        .ready     (j_ready),
        .load_ready(j_load_ready)
    );

    operand_snoop u_k (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .load      (accept),
        .load_tag  (k_load_tag),
        .load_val  (k_load_val),
        .cdb_data  (cdb_data),
        .cdb_valid (cdb_valid),
        .value     (k_val),
        .ready     (k_ready),
        .load_ready(k_load_ready)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = (j_load_ready && k_load_ready)
                            ? S_EXEC : S_WAIT;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                if (j_ready && k_ready) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end
            end
            S_EXEC: begin
                if (cnt == CW'(ADD_LATENCY - 1)) state_n = S_DONE;
                else cnt_n = cnt + 1'b1;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (kill) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= INST_ADD;
            tag_q    <= '0;
            res_rb   <= '0;
            res_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_q  <= op_in;
                tag_q <= issue_rb;
            end
            if (state == S_EXEC && state_n == S_DONE) begin
                res_rb   <= tag_q;
                res_data <= result;
            end
        end
    end

    // The ROB must never issue to an occupied station.
    issue_when_busy: assert property (
        @(posedge clk) disable iff (reset)
        !(busy && !kill && issue_fu == FU_INDEX'(FU_ID))
    ) else $error("adder_station: fatal, issue to busy FU");

    unknown_opcode: assert property (
        @(posedge clk) disable iff (reset)
        !(accept && op_in != INST_ADD && op_in != INST_SUB
          && op_in != INST_ADDI && op_in != INST_SUBI)
    ) else $warning("adder_station: unknown opcode, using ADD");

endmodule

// File: tb/tb_adder_station.sv
// Directed bench for adder_station: latency, snooping,
// kill in every busy state and async reset.
module tb_adder_station;
    import adder_station_pkg::*;

    logic          clk;
    logic          reset;
    logic          kill;
    logic [3:0]    issue_fu;
    logic [31:0]   issue_inst;
    logic [3:0]    issue_rb;
    logic [4:0]    numj, numk;
    logic [31:0]   vj, vk;
    logic [3:0]    qj, qk;
    logic [255:0]  cdb_data;
    logic [7:0]    cdb_valid;
    logic          busy, res_valid;
    logic [3:0]    res_rb;
    logic [31:0]   res_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen;

    adder_station #(.FU_ID(0), .ADD_LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .issue_fu  (issue_fu),
        .issue_inst(issue_inst),
        .issue_rb  (issue_rb),
        .numj      (numj),
        .numk      (numk),
        .vj        (vj),
        .vk        (vk),
        .qj        (qj),
        .qk        (qk),
        .cdb_data  (cdb_data),
        .cdb_valid (cdb_valid),
        .busy      (busy),
        .res_valid (res_valid),
        .res_rb    (res_rb),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [3:0] op,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
        return {op, 5'd1, rs, rt, 13'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] op,
                                        input logic [4:0] rs,
                                        input logic [17:0] imm);
        return {op, 5'd1, rs, imm};
    endfunction

    task automatic issue(input logic [31:0] inst,
                         input logic [3:0]  rb,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [3:0]  tj,
                         input logic [3:0]  tk);
        issue_fu   = 4'd0;
        issue_inst = inst;
        issue_rb   = rb;
        vj = a;
        vk = b;
        qj = tj;
        qk = tk;
        tick();
        issue_fu = 4'hF;
        qj = 4'hF;
        qk = 4'hF;
    endtask

    // Counts edges until res_valid, bounded, then checks
    // latency, payload and the one-cycle strobe.
    task automatic expect_result(input string tag,
                                 input int start,
                                 input int want_n,
                                 input logic [3:0] rb,
                                 input logic [31:0] data);
        int n;
        n = start;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, want_n);
        check({tag, "_rb"}, {28'd0, res_rb}, {28'd0, rb});
        check({tag, "_data"}, res_data, data);
        tick();
        check({tag, "_vdrop"}, {31'd0, res_valid}, 0);
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | res_valid;
        end
        check({tag, "_noval"}, {31'd0, seen}, 0);
    endtask

    initial begin
        reset      = 1'b1;
        kill       = 1'b0;
        issue_fu   = 4'hF;
        issue_inst = '0;
        issue_rb   = '0;
        vj = '0;
        vk = '0;
        qj = 4'hF;
        qk = 4'hF;
        cdb_data  = '0;
        cdb_valid = '0;
        #3;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {31'd0, res_valid}, 0);
        check("rst_rb", {28'd0, res_rb}, 0);
        check("rst_data", res_data, 0);
        issue_inst = mk_r(INST_ADD, 5'd9, 5'd17);
        #1;
        check("numj", {27'd0, numj}, 9);
        check("numk", {27'd0, numk}, 17);
        reset = 1'b0;
        tick();

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd3, 7, 5, 4'hF, 4'hF);
        check("add_busy", {31'd0, busy}, 1);
        expect_result("add", 1, 3, 4'd3, 32'd12);

        issue(mk_i(INST_SUBI, 5'd1, 18'h3FFFF), 4'd4, 10, 99,
              4'hF, 4'd2);
        expect_result("subi", 1, 3, 4'd4, 32'd11);

        issue(mk_r(INST_SUB, 5'd1, 5'd2), 4'd0, 3, 5, 4'hF, 4'hF);
        expect_result("sub", 1, 3, 4'd0, 32'hFFFFFFFE);

        cdb_valid = 8'h10;
        cdb_data[4*32 +: 32] = 32'd50;
        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd1, 0, 6, 4'd4, 4'hF);
        cdb_valid = '0;
        expect_result("cdbacc", 1, 3, 4'd1, 32'd56);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd2, 32'hDEAD, 1,
              4'd2, 4'hF);
        cdb_valid = 8'h20;
        cdb_data[5*32 +: 32] = 32'd777;
        quiet("snwait", 4);
        cdb_valid = 8'h04;
        cdb_data[2*32 +: 32] = 32'd100;
        tick();
        cdb_valid = '0;
        expect_result("snoop", 0, 3, 4'd2, 32'd101);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd5, 0, 0, 4'd1, 4'd6);
        quiet("bwait", 2);
        cdb_valid = 8'h42;
        cdb_data[1*32 +: 32] = 32'd1000;
        cdb_data[6*32 +: 32] = 32'd234;
        tick();
        cdb_valid = '0;
        expect_result("both", 0, 3, 4'd5, 32'd1234);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd6, 0, 1, 4'd2, 4'hF);
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kwait_busy", {31'd0, busy}, 0);
        cdb_valid = 8'h04;
        quiet("kwait", 4);
        cdb_valid = '0;

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd6, 8, 9, 4'hF, 4'hF);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kexec_busy", {31'd0, busy}, 0);
        quiet("kexec", 4);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd2, 1, 1, 4'hF, 4'hF);
        tick();
        tick();
        check("kdone_pre", {31'd0, res_valid}, 1);
        kill = 1'b1;
        #1;
        check("kdone_gate", {31'd0, res_valid}, 0);
        tick();
        kill = 1'b0;
        check("kdone_busy", {31'd0, busy}, 0);
        check("kdone_val", {31'd0, res_valid}, 0);

        kill       = 1'b1;
        issue_fu   = 4'd0;
        issue_inst = mk_r(INST_ADD, 5'd1, 5'd2);
        tick();
        kill     = 1'b0;
        issue_fu = 4'hF;
        check("kiss_busy", {31'd0, busy}, 0);
        quiet("kiss", 3);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd7, 20, 22, 4'hF, 4'hF);
        expect_result("postk", 1, 3, 4'd7, 32'd42);

        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd6, 30, 40, 4'hF, 4'hF);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_valid", {31'd0, res_valid}, 0);
        check("arst_rb", {28'd0, res_rb}, 0);
        check("arst_data", res_data, 0);
        reset = 1'b0;
        quiet("arst", 3);
        issue(mk_r(INST_ADD, 5'd1, 5'd2), 4'd5, 1, 2, 4'hF, 4'hF);
        expect_result("postrst", 1, 3, 4'd5, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
